// File: rtl/wb_module_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_module_bridge_if
//
// Wishbone slave-side bus bundle for wb_module_bridge. Signal names keep the
// Wishbone _i/_o suffixes as seen from the slave, so the bridge and any other
// Wishbone slave read the same way.
//
// Signals:
//   wbs_cyc_i  1   cycle valid (master -> slave)
//   wbs_stb_i  1   strobe (master -> slave)
//   wbs_we_i   1   1 = write, 0 = read (master -> slave)
//   wbs_sel_i  4   byte enables (master -> slave)
//   wbs_adr_i  32  byte address (master -> slave)
//   wbs_dat_i  32  write data (master -> slave)
//   wbs_ack_o  1   single-cycle acknowledge (slave -> master)
//   wbs_dat_o  32  read data, valid with wbs_ack_o (slave -> master)
//
// Modports:
//   master  drives the request side, observes ack/data
//   slave   observes the request side, drives ack/data
// -----------------------------------------------------------------------------
interface wb_module_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/wb_module_bridge.sv
// -----------------------------------------------------------------------------
// wb_module_bridge
//
// Bridges a 256-byte Wishbone window (at BASE_ADDR) onto a small module
// decoder. Each accepted request runs IDLE -> SETUP -> [WAIT] -> ACK -> IDLE:
// the module select and write data are presented during SETUP/WAIT, a write
// strobe is issued for the SETUP cycle, and the decoder's muxed read data is
// captured on the edge entering ACK. The ack itself is registered, so it is
// visible during the cycle after the ACK state, i.e. 2 + READ_WAIT edges after
// the edge that sampled the request.
//
// Parameters:
//   BASE_ADDR  window base; only bits [31:8] are compared
//   READ_WAIT  settle cycles between select setup and data capture (0..15)
//
// Ports:
//   wb_clk_i     in   clock, all state changes on its rising edge
//   wb_rst_i     in   synchronous active-high reset
//   wbs          if   Wishbone slave bundle (wb_module_bridge_if.slave)
//   mod_addr_o   out  3   module select: 0 = none, 1..4 = module 0..3
//   mod_we_o     out  1   one-cycle write strobe toward the decoder
//   mod_wdata_o  out  32  write data toward the modules
//   mod_rdata_i  in   32  decoder read data for the current mod_addr_o
//   busy_o       out  1   high whenever the FSM is not in IDLE
//   err_o        out  1   sticky error: bad select (5..7) or partial write
// -----------------------------------------------------------------------------
module wb_module_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_module_bridge_if.slave  wbs,
    output logic [2:0]         mod_addr_o,
    output logic               mod_we_o,
    output logic [31:0]        mod_wdata_o,
    input  logic [31:0]        mod_rdata_i,
    output logic               busy_o,
    output logic               err_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // The WAIT counter starts at 0 on entry and leaves when it reaches
    // READ_WAIT-1, giving exactly READ_WAIT cycles in WAIT. With no wait
    // cycles the WAIT state is never entered and this value is unused.
    localparam logic       HAS_WAIT  = (READ_WAIT != 0);
    localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(READ_WAIT - 1) : 4'd0;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  state_reg,    state_next;
    logic [3:0]  cnt_reg,      cnt_next;
    logic [2:0]  sel_reg,      sel_next;
    logic        write_reg,    write_next;
    logic [31:0] wdata_reg,    wdata_next;
    logic        ack_reg,      ack_next;
    logic [31:0] dat_reg,      dat_next;
    logic [2:0]  mod_addr_reg, mod_addr_next;
    logic        mod_we_reg,   mod_we_next;
    logic        busy_reg,     busy_next;
    logic        err_reg,      err_next;

    // ------------------------------------------------------------------
    // Request decode (combinational, from the live bus)
    // ------------------------------------------------------------------
    logic        addr_hit;
    logic        req_valid;
    logic [2:0]  req_sel;
    logic        req_sel_module;   // select names a real module (1..4)
    logic        req_sel_bad;      // select is out of range (5..7)
    logic        req_be_full;
    logic        req_write_ok;
    logic        req_error;

    assign addr_hit       = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req_sel        = wbs.wbs_adr_i[4:2];
    assign req_sel_bad    = req_sel[2] & (|req_sel[1:0]);
    assign req_sel_module = (req_sel != 3'd0) & ~req_sel_bad;
    assign req_be_full    = &wbs.wbs_sel_i;

    // A write reaches a module only when it targets a real module with all
    // four byte enables; the modules have no byte-lane write support, so a
    // partial write is acked but silently dropped.
    assign req_write_ok = wbs.wbs_we_i & req_sel_module & req_be_full;
    assign req_error    = req_sel_bad | (wbs.wbs_we_i & ~req_be_full);

    // The cycle right after an ack is a dead cycle: the master still sees
    // its strobe high for that edge and must not have it taken as a new
    // request.
    assign req_valid = wbs.wbs_cyc_i & wbs.wbs_stb_i & addr_hit & ~ack_reg;

    // ------------------------------------------------------------------
    // Read data gating: out-of-range selects and writes return zero.
    // ------------------------------------------------------------------
    logic        rd_allow;
    logic [31:0] rdata_gated;

    assign rd_allow = ~write_reg & ~(sel_reg[2] & (|sel_reg[1:0]));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rdata_gated[gi*8 +: 8] = rd_allow ? mod_rdata_i[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        write_next = write_reg;
        wdata_next = wdata_reg;
        ack_next   = 1'b0;
        dat_next   = dat_reg;
        mod_we_next = 1'b0;
        err_next   = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    sel_next    = req_sel;
                    write_next  = wbs.wbs_we_i;
                    wdata_next  = wbs.wbs_dat_i;
                    mod_we_next = req_write_ok;
                    err_next    = err_reg | req_error;
                    state_next  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (!wbs.wbs_cyc_i) begin
                    // Master abandoned the cycle; any strobe already issued
                    // stands, we just stop presenting the select.
                    state_next = ST_IDLE;
                end else if (HAS_WAIT) begin
                    cnt_next   = 4'd0;
                    state_next = ST_WAIT;
                end else begin
                    dat_next   = rdata_gated;
                    state_next = ST_ACK;
                end
            end

            ST_WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    cnt_next   = 4'd0;
                    state_next = ST_IDLE;
                end else if (cnt_reg == WAIT_LAST) begin
                    cnt_next   = 4'd0;
                    dat_next   = rdata_gated;
                    state_next = ST_ACK;
                end else begin
                    cnt_next   = cnt_reg + 4'd1;
                end
            end

            ST_ACK: begin
                ack_next   = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents.
        // The select drops to zero on the edge entering ACK, after the read
        // data has been captured from the decoder.
        if ((state_next == ST_SETUP) || (state_next == ST_WAIT)) begin
            mod_addr_next = sel_next;
        end else begin
            mod_addr_next = 3'd0;
        end
        busy_next = (state_next != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            sel_reg      <= 3'd0;
            write_reg    <= 1'b0;
            wdata_reg    <= 32'h0;
            ack_reg      <= 1'b0;
            dat_reg      <= 32'h0;
            mod_addr_reg <= 3'd0;
            mod_we_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            write_reg    <= write_next;
            wdata_reg    <= wdata_next;
            ack_reg      <= ack_next;
            dat_reg      <= dat_next;
            mod_addr_reg <= mod_addr_next;
            mod_we_reg   <= mod_we_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;
    assign mod_addr_o    = mod_addr_reg;
    assign mod_we_o      = mod_we_reg;
    assign mod_wdata_o   = wdata_reg;
    assign busy_o        = busy_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_wb_module_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_module_bridge
//
// Drives three bridges from one shared request stream: dut0 with default
// parameters (main checks), dut1 with READ_WAIT = 0 and dut2 with
// READ_WAIT = 15 (latency checks). Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_module_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  be;
    logic [31:0] adr, wdat, rdata;

    wb_module_bridge_if bus0 ();
    wb_module_bridge_if bus1 ();
    wb_module_bridge_if bus2 ();

    assign bus0.wbs_cyc_i = cyc;  assign bus1.wbs_cyc_i = cyc;  assign bus2.wbs_cyc_i = cyc;
    assign bus0.wbs_stb_i = stb;  assign bus1.wbs_stb_i = stb;  assign bus2.wbs_stb_i = stb;
    assign bus0.wbs_we_i  = we;   assign bus1.wbs_we_i  = we;   assign bus2.wbs_we_i  = we;
    assign bus0.wbs_sel_i = be;   assign bus1.wbs_sel_i = be;   assign bus2.wbs_sel_i = be;
    assign bus0.wbs_adr_i = adr;  assign bus1.wbs_adr_i = adr;  assign bus2.wbs_adr_i = adr;
    assign bus0.wbs_dat_i = wdat; assign bus1.wbs_dat_i = wdat; assign bus2.wbs_dat_i = wdat;

    logic [2:0]  mod_addr0, mod_addr1, mod_addr2;
    logic        mod_we0, mod_we1, mod_we2;
    logic [31:0] mod_wdata0, mod_wdata1, mod_wdata2;
    logic        busy0, busy1, busy2;
    logic        err0, err1, err2;

    wb_module_bridge dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0),
        .mod_addr_o(mod_addr0), .mod_we_o(mod_we0), .mod_wdata_o(mod_wdata0),
        .mod_rdata_i(rdata), .busy_o(busy0), .err_o(err0)
    );

    wb_module_bridge #(.READ_WAIT(0)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1),
        .mod_addr_o(mod_addr1), .mod_we_o(mod_we1), .mod_wdata_o(mod_wdata1),
        .mod_rdata_i(rdata), .busy_o(busy1), .err_o(err1)
    );

    wb_module_bridge #(.READ_WAIT(15)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus2),
        .mod_addr_o(mod_addr2), .mod_we_o(mod_we2), .mod_wdata_o(mod_wdata2),
        .mod_rdata_i(rdata), .busy_o(busy2), .err_o(err2)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_ack;
        logic [2:0]  exp_addr;
        int          exp_pulses;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    // One full transaction on dut0; strobe is held until ack (or timeout).
    task automatic run_txn(input vec_t v,
                           output logic acked, output int lat, output int pulses,
                           output logic [2:0] addr_c0, output logic [31:0] wdata_at_we,
                           output logic [31:0] dat_at_ack, output logic busy_any,
                           output logic ack_after);
        acked = 1'b0; lat = -1; pulses = 0; addr_c0 = 3'd0; wdata_at_we = 32'h0;
        dat_at_ack = 32'h0; busy_any = 1'b0; ack_after = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; be = v.be;
        wdat = v.wdata; rdata = v.rdata;
        @(posedge clk);            // request-sampling edge
        @(negedge clk);
        addr_c0 = mod_addr0;
        for (int c = 0; c <= 20; c++) begin
            if (busy0) busy_any = 1'b1;
            if (mod_we0) begin
                pulses++;
                wdata_at_we = mod_wdata0;
            end
            if (bus0.wbs_ack_o) begin
                acked = 1'b1;
                lat = c;
                dat_at_ack = bus0.wbs_dat_o;
                break;
            end
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        ack_after = bus0.wbs_ack_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acked, busy_any, ack_after;
        int          lat, pulses, first_ack, second_ack, ack_cnt, lat1, lat2;
        logic [2:0]  addr_c0;
        logic [31:0] wdata_at_we, dat_at_ack, dat1, dat2;

        //            we    adr            be    wdata          rdata          ack   addr  pul dat            err
        vecs[0] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         32'h8BAD_F00D, 1'b1, 3'd2, 0, 32'h8BAD_F00D, 1'b0};
        vecs[1] = '{1'b1, 32'h3000_0010, 4'hF, 32'hFEED_C0DE, 32'h1234_5678, 1'b1, 3'd4, 1, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         32'hA5A5_0001, 1'b1, 3'd1, 0, 32'hA5A5_0001, 1'b0};
        vecs[3] = '{1'b0, 32'h3000_00E8, 4'hF, 32'h0,         32'h0F0F_0F0F, 1'b1, 3'd2, 0, 32'h0F0F_0F0F, 1'b0};
        vecs[4] = '{1'b1, 32'h3000_000C, 4'hF, 32'h1357_2468, 32'h0,         1'b1, 3'd3, 1, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 32'h3100_0004, 4'hF, 32'h0,         32'h5555_5555, 1'b0, 3'd0, 0, 32'h0,         1'b0};
        vecs[6] = '{1'b1, 32'h3000_0004, 4'h3, 32'h1122_3344, 32'h0,         1'b1, 3'd1, 0, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 32'h3000_001C, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b1, 3'd7, 0, 32'h0,         1'b1};
        vecs[8] = '{1'b1, 32'h3000_0000, 4'hF, 32'h9999_9999, 32'h0,         1'b1, 3'd0, 0, 32'h0,         1'b1};
        vecs[9] = '{1'b0, 32'h3000_0014, 4'hF, 32'h0,         32'h7777_7777, 1'b1, 3'd5, 0, 32'h0,         1'b1};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; be = 4'h0;
        adr = 32'h0; wdat = 32'h0; rdata = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(bus0.wbs_ack_o), 32'h0);
        check("rst_dat",   bus0.wbs_dat_o,      32'h0);
        check("rst_addr",  32'(mod_addr0),      32'h0);
        check("rst_we",    32'(mod_we0),        32'h0);
        check("rst_wdata", mod_wdata0,          32'h0);
        check("rst_busy",  32'(busy0),          32'h0);
        check("rst_err",   32'(err0),           32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- table vectors ----------------
        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i], acked, lat, pulses, addr_c0, wdata_at_we, dat_at_ack, busy_any, ack_after);
            $display("txn %0d: we=%0d adr=%h be=%h ack=%0d lat=%0d pulses=%0d addr=%0d dat=%h err=%0d",
                     i, vecs[i].we, vecs[i].adr, vecs[i].be, acked, lat, pulses, addr_c0, dat_at_ack, err0);
            check($sformatf("v%0d_ack", i),    32'(acked),    32'(vecs[i].exp_ack));
            check($sformatf("v%0d_pulses", i), 32'(pulses),   32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_addr", i),   32'(addr_c0),  32'(vecs[i].exp_addr));
            check($sformatf("v%0d_busy", i),   32'(busy_any), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_err", i),    32'(err0),     32'(vecs[i].exp_err));
            if (vecs[i].exp_ack) begin
                check($sformatf("v%0d_lat", i),      32'(lat),       32'd3);
                check($sformatf("v%0d_dat", i),      dat_at_ack,     vecs[i].exp_dat);
                check($sformatf("v%0d_ack_len", i),  32'(ack_after), 32'h0);
            end
            if (vecs[i].exp_pulses > 0) begin
                check($sformatf("v%0d_wdata", i), wdata_at_we, vecs[i].wdata);
            end
        end

        // ---------------- cyc dropped in WAIT ----------------
        repeat (2) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0008; be = 4'hF; wdat = 32'hABCD_0123;
        @(posedge clk);
        @(negedge clk);                         // SETUP
        check("abort_we_pulse", 32'(mod_we0), 32'h1);
        @(negedge clk);                         // WAIT
        check("abort_addr_wait", 32'(mod_addr0), 32'h2);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("abort_addr_idle", 32'(mod_addr0), 32'h0);
        check("abort_busy",      32'(busy0),     32'h0);
        check("abort_we",        32'(mod_we0),   32'h0);
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus0.wbs_ack_o) ack_cnt++;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(ack_cnt), 32'h0);
        $display("seq abort-in-wait: acks=%0d", ack_cnt);

        // ---------------- back-to-back with strobe held ----------------
        repeat (2) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; be = 4'hF; rdata = 32'h600D_F00D;
        @(posedge clk);
        @(negedge clk);
        first_ack = -1; second_ack = -1; dat_at_ack = 32'h0;
        for (int c = 0; c <= 15; c++) begin
            if (bus0.wbs_ack_o) begin
                if (first_ack < 0) begin
                    first_ack = c;
                    dat_at_ack = bus0.wbs_dat_o;
                end else if (second_ack < 0) begin
                    second_ack = c;
                end
            end
            if (c < 15) @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b_first_ack",  32'(first_ack),  32'd3);
        check("b2b_second_ack", 32'(second_ack), 32'd8);
        check("b2b_dat",        dat_at_ack,      32'h600D_F00D);
        $display("seq back-to-back: first=%0d second=%0d dat=%h", first_ack, second_ack, dat_at_ack);

        // ---------------- reset asserted in WAIT ----------------
        repeat (3) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_000C; be = 4'hF; rdata = 32'h0BAD_CAFE;
        @(posedge clk);
        @(negedge clk);                         // SETUP
        check("rstw_busy_before", 32'(busy0), 32'h1);
        check("rstw_err_before",  32'(err0),  32'h1);
        @(negedge clk);                         // WAIT
        rst = 1'b1;
        @(negedge clk);
        check("rstw_addr",  32'(mod_addr0),     32'h0);
        check("rstw_busy",  32'(busy0),         32'h0);
        check("rstw_err",   32'(err0),          32'h0);
        check("rstw_dat",   bus0.wbs_dat_o,     32'h0);
        check("rstw_wdata", mod_wdata0,         32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus0.wbs_ack_o) ack_cnt++;
            @(negedge clk);
        end
        check("rstw_no_ack", 32'(ack_cnt), 32'h0);
        $display("seq reset-in-wait: acks=%0d err=%0d", ack_cnt, err0);

        // ---------------- READ_WAIT = 0 and 15 latency ----------------
        repeat (2) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0008; be = 4'hF; rdata = 32'h1234_ABCD;
        @(posedge clk);
        @(negedge clk);
        lat1 = -1; lat2 = -1; dat1 = 32'h0; dat2 = 32'h0;
        for (int c = 0; c <= 24; c++) begin
            if (bus1.wbs_ack_o && lat1 < 0) begin
                lat1 = c;
                dat1 = bus1.wbs_dat_o;
            end
            if (bus2.wbs_ack_o && lat2 < 0) begin
                lat2 = c;
                dat2 = bus2.wbs_dat_o;
            end
            if (c < 24) @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0;
        check("rw0_lat",  32'(lat1), 32'd2);
        check("rw0_dat",  dat1,      32'h1234_ABCD);
        check("rw15_lat", 32'(lat2), 32'd17);
        check("rw15_dat", dat2,      32'h1234_ABCD);
        $display("seq latency: rw0=%0d rw15=%0d", lat1, lat2);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
